kernel_loader: RTL and testbench

Transmit side of the kernel weight stream. Accepts wide words from the memory/DMA read port, splits each into STR_KER_WIDTH lanes and drives the `str_ker` valid/ready stream into `kernel`. A single configuration write sets how many lanes make up one load. The block stops after the last lane and pulses `done`.

---
 rtl/kernel_loader_pkg.sv | 16 +
 rtl/str_downsize.sv | 70 +++++++
 rtl/kernel_loader.sv | 102 ++++++++++
 tb/tb_kernel_loader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_loader_pkg.sv
// Shared config address map and FSM encodings for the kernel loader.
// CFG_KER_LD starts a kernel load of cfg_data+1 lanes.
package kernel_loader_pkg;

    localparam int CFG_KER_WR = 4;
    localparam int CFG_KER_RD = 5;
    localparam int CFG_KER_LD = 6;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    function automatic int lane_idx_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/str_downsize.sv
// Wide-to-narrow stream splitter: one holding word, lane index, registered lane.
// REVERSE=1 emits the most significant lane first.
module str_downsize
    import kernel_loader_pkg::*;
#(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 16,
    parameter bit REVERSE   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 drop,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_val,
    output logic                 in_rdy,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_val,
    input  logic                 out_rdy
);

    localparam int L  = IN_WIDTH / OUT_WIDTH;
    localparam int IW = lane_idx_width(L);

    logic [IN_WIDTH-1:0] hold;
    logic [IW-1:0]       idx;
    logic                full;
    logic                out_fire;
    logic                in_fire;
    logic                word_end;

    function automatic logic [OUT_WIDTH-1:0] lane(
        input logic [IN_WIDTH-1:0] w,
        input logic [IW-1:0]       i
    );
        if (REVERSE)
            return w[IN_WIDTH-1-int'(i)*OUT_WIDTH -: OUT_WIDTH];
        else
            return w[int'(i)*OUT_WIDTH +: OUT_WIDTH];
    endfunction

    assign out_val  = full;
    assign out_fire = full && out_rdy;
    assign word_end = (idx == IW'(L-1));
    assign in_rdy   = en && (!full || (out_fire && word_end));
    assign in_fire  = in_rdy && in_val;

    // drop ends the word early: its remaining lanes are discarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold     <= '0;
            idx      <= '0;
            full     <= 1'b0;
            out_data <= '0;
        end else if (in_fire) begin
            hold     <= in_data;
            idx      <= '0;
            full     <= 1'b1;
            out_data <= lane(in_data, '0);
        end else if (out_fire) begin
            if (word_end || drop) begin
                full <= 1'b0;
            end else begin
                idx      <= idx + 1'b1;
                out_data <= lane(hold, idx + 1'b1);
            end
        end
    end

endmodule

// File: rtl/kernel_loader.sv
// Kernel weight stream loader: config decode, IDLE/RUN FSM, lane count, done.
// Define KERNEL_LOADER_SWAP_EN to emit lanes most-significant first.
module kernel_loader
    import kernel_loader_pkg::*;
#(
    parameter int CFG_DWIDTH    = 32,
    parameter int CFG_AWIDTH    = 5,
    parameter int IN_WIDTH      = 64,
    parameter int STR_KER_WIDTH = 16,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CFG_DWIDTH-1:0]    cfg_data,
    input  logic [CFG_AWIDTH-1:0]    cfg_addr,
    input  logic                     cfg_valid,
    input  logic [IN_WIDTH-1:0]      in_data,
    input  logic                     in_val,
    output logic                     in_rdy,
    output logic [STR_KER_WIDTH-1:0] str_ker,
    output logic                     str_ker_val,
    input  logic                     str_ker_rdy,
    output logic                     busy,
    output logic                     done
);

    localparam int L = IN_WIDTH / STR_KER_WIDTH;
`ifdef KERNEL_LOADER_SWAP_EN
    localparam bit REV = 1'b1;
`else
    localparam bit REV = 1'b0;
`endif

    logic [0:0]           state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] last;
    logic [CNT_WIDTH:0]   owed;
    logic                 run;
    logic                 ld;
    logic                 lane_fire;
    logic                 final_fire;
    logic                 word_fire;

    if (CFG_DWIDTH > CNT_WIDTH) begin : g_cfg_hi
        logic unused_cfg_hi;
        assign unused_cfg_hi = ^cfg_data[CFG_DWIDTH-1:CNT_WIDTH];
    end

    assign run        = (state == S_RUN);
    assign ld         = !run && cfg_valid
                        && (cfg_addr == CFG_AWIDTH'(CFG_KER_LD));
    assign lane_fire  = str_ker_val && str_ker_rdy;
    assign final_fire = run && lane_fire && (cnt == last);
    assign word_fire  = in_val && in_rdy;
    assign busy       = run;

    str_downsize #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (STR_KER_WIDTH),
        .REVERSE   (REV)
    ) u_down (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (run && (owed != '0)),
        .drop     (cnt == last),
        .in_data  (in_data),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .out_data (str_ker),
        .out_val  (str_ker_val),
        .out_rdy  (str_ker_rdy)
    );

    // owed counts lanes not yet covered by an accepted word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            last  <= '0;
            owed  <= '0;
            done  <= 1'b0;
        end else begin
            done <= final_fire;
            if (ld) begin
                state <= S_RUN;
                cnt   <= '0;
                last  <= cfg_data[CNT_WIDTH-1:0];
                owed  <= {1'b0, cfg_data[CNT_WIDTH-1:0]}
                         + (CNT_WIDTH+1)'(1);
            end else begin
                if (final_fire)
                    state <= S_IDLE;
                if (run && lane_fire)
                    cnt <= cnt + 1'b1;
                if (word_fire)
                    owed <= (owed > (CNT_WIDTH+1)'(L))
                            ? owed - (CNT_WIDTH+1)'(L) : '0;
            end
        end
    end

endmodule

// File: tb/tb_kernel_loader.sv
// Directed scoreboard bench for kernel_loader.
// Define KERNEL_LOADER_SWAP_EN to check descending lane order.
module tb_kernel_loader;

    localparam logic [4:0] LD_ADDR = 5'd6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cfg_data;
    logic [4:0]  cfg_addr;
    logic        cfg_valid;
    logic [63:0] in_data;
    logic        in_val;
    logic        in_rdy;
    logic [15:0] str_ker;
    logic        str_ker_val;
    logic        str_ker_rdy;
    logic        busy;
    logic        done;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] src_q[$];
    logic [15:0] exp_q[$];
    logic        busy_m = 1'b0;
    logic        done_m = 1'b0;
    int          lanes_left = 0;
    bit          toggle = 1'b0;
    int          steps;

    localparam logic [63:0] W1 = 64'h0004_0003_0002_0001;
    localparam logic [63:0] W2 = 64'h0008_0007_0006_0005;
    localparam logic [63:0] W3 = 64'h000c_000b_000a_0009;

    always #5 clk = ~clk;

    kernel_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_data    (cfg_data),
        .cfg_addr    (cfg_addr),
        .cfg_valid   (cfg_valid),
        .in_data     (in_data),
        .in_val      (in_val),
        .in_rdy      (in_rdy),
        .str_ker     (str_ker),
        .str_ker_val (str_ker_val),
        .str_ker_rdy (str_ker_rdy),
        .busy        (busy),
        .done        (done)
    );

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lane_of(logic [63:0] w, int i);
`ifdef KERNEL_LOADER_SWAP_EN
        return w[63-16*i -: 16];
`else
        return w[16*i +: 16];
`endif
    endfunction

    task automatic check_reset_outs(string tag);
        check({tag, "_in_rdy"}, 64'(in_rdy), 64'd0);
        check({tag, "_str_ker"}, 64'(str_ker), 64'd0);
        check({tag, "_val"}, 64'(str_ker_val), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
    endtask

    // called at a negedge: score this cycle, advance one clock
    task automatic step();
        logic busy_nx;
        logic done_nx;
        busy_nx = busy_m;
        done_nx = 1'b0;
        check("busy", 64'(busy), 64'(busy_m));
        check("done", 64'(done), 64'(done_m));
        if (!busy_m)
            check("in_rdy_idle", 64'(in_rdy), 64'd0);
        if (str_ker_val && str_ker_rdy) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL extra_lane: observed %0h expected none", str_ker);
            end else begin
                check("lane", 64'(str_ker), 64'(exp_q.pop_front()));
            end
            if (lanes_left == 1) begin
                done_nx = 1'b1;
                busy_nx = 1'b0;
            end
            if (lanes_left > 0)
                lanes_left--;
        end
        if (in_val && in_rdy && src_q.size() != 0)
            void'(src_q.pop_front());
        if (cfg_valid && cfg_addr == LD_ADDR && !busy_m) begin
            busy_nx = 1'b1;
            lanes_left = int'(cfg_data[15:0]) + 1;
        end
        @(posedge clk);
        busy_m = busy_nx;
        done_m = done_nx;
        #1;
        cfg_valid = 1'b0;
        in_val = (src_q.size() != 0);
        in_data = (src_q.size() != 0) ? src_q[0] : 64'd0;
        str_ker_rdy = toggle ? ~str_ker_rdy : 1'b1;
        @(negedge clk);
    endtask

    task automatic load(int n, int nwords, logic [63:0] a,
                        logic [63:0] b, logic [63:0] c);
        logic [63:0] w[3];
        w[0] = a;
        w[1] = b;
        w[2] = c;
        for (int k = 0; k < nwords; k++)
            src_q.push_back(w[k]);
        for (int k = 0; k < n; k++)
            exp_q.push_back(lane_of(w[k/4], k%4));
        in_val = 1'b1;
        in_data = src_q[0];
        cfg_data = 32'(n - 1);
        cfg_addr = LD_ADDR;
        cfg_valid = 1'b1;
    endtask

    task automatic run_to_idle(string tag);
        steps = 0;
        step();
        steps++;
        while ((busy_m || exp_q.size() != 0) && steps < 200) begin
            step();
            steps++;
        end
        if (steps >= 200) begin
            vectors++;
            miscompares++;
            $error("FAIL %s_timeout: observed %0d left expected 0",
                   tag, exp_q.size());
        end
    endtask

    task automatic flush_model();
        src_q.delete();
        exp_q.delete();
        busy_m = 1'b0;
        done_m = 1'b0;
        lanes_left = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_data = '0;
        cfg_addr = '0;
        cfg_valid = 1'b0;
        in_data = W1;
        in_val = 1'b1;
        str_ker_rdy = 1'b1;

        repeat (6) begin
            @(negedge clk);
            check_reset_outs("reset");
        end
        rst_n = 1'b1;

        // word offered with no config write: never taken
        src_q.push_back(W1);
        repeat (4) step();
        check("no_cfg_word_kept", 64'(src_q.size()), 64'd1);
        flush_model();

        load(8, 2, W1, W2, 64'd0);
        run_to_idle("n8");
        check("n8_cycles", 64'(steps), 64'd10);
        repeat (3) step();

        load(6, 3, W1, W2, W3);
        run_to_idle("n6");
        repeat (3) step();
        check("n6_words_left", 64'(src_q.size()), 64'd1);
        flush_model();
        step();

        toggle = 1'b1;
        load(4, 1, W1, 64'd0, 64'd0);
        run_to_idle("toggle");
        toggle = 1'b0;
        repeat (3) step();

        // load request mid-run must not change the length
        load(8, 2, W1, W2, 64'd0);
        repeat (4) step();
        cfg_data = 32'd1;
        cfg_addr = LD_ADDR;
        cfg_valid = 1'b1;
        run_to_idle("midrun");
        repeat (3) step();

        // load request on the final-accept edge is dropped
        load(4, 1, W1, 64'd0, 64'd0);
        steps = 0;
        while (!(exp_q.size() == 1 && str_ker_val && str_ker_rdy)
               && steps < 50) begin
            step();
            steps++;
        end
        check("final_edge_reached", 64'(exp_q.size()), 64'd1);
        cfg_data = 32'd1;
        cfg_addr = LD_ADDR;
        cfg_valid = 1'b1;
        repeat (5) step();
        check("final_edge_idle", 64'(busy), 64'd0);

        // abandon a load after 3 lanes
        load(8, 2, W1, W2, 64'd0);
        steps = 0;
        while (exp_q.size() > 5 && steps < 50) begin
            step();
            steps++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outs("async_rst");
        flush_model();
        in_val = 1'b0;
        @(negedge clk);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (4) step();

        load(4, 1, W1, 64'd0, 64'd0);
        run_to_idle("after_rst");
        check("after_rst_cycles", 64'(steps), 64'd6);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
